// File: rtl/glb_port_arbiter.sv
// Two-requester GLB arbiter: fixed priority to the controller, starvation counter for the loader,
// with a tag pipeline that steers read data back to whichever side issued the read.
module glb_port_arbiter #(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           c_re,
  input  logic [31:0]          c_r_addr,
  output logic                 c_r_gnt,
  output logic                 c_r_valid,
  output logic [DATA_SIZE-1:0] c_r_data,
  input  logic [3:0]           c_we,
  input  logic [31:0]          c_w_addr,
  input  logic [DATA_SIZE-1:0] c_w_data,
  output logic                 c_w_gnt,
  input  logic [3:0]           d_re,
  input  logic [31:0]          d_r_addr,
  output logic                 d_r_gnt,
  output logic                 d_r_valid,
  output logic [DATA_SIZE-1:0] d_r_data,
  input  logic [3:0]           d_we,
  input  logic [31:0]          d_w_addr,
  input  logic [DATA_SIZE-1:0] d_w_data,
  output logic                 d_w_gnt,
  output logic [3:0]           glb_re,
  output logic [31:0]          glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic [3:0]           glb_we,
  output logic [31:0]          glb_w_addr,
  output logic [DATA_SIZE-1:0] glb_w_data
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             run;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             c_r_req, d_r_req, c_w_req, d_w_req;
  logic             c_r_win, d_r_win, c_w_win, d_w_win;
  logic             d_r_deny, d_w_deny;
  logic             tag_vld [READ_LAT];
  logic             tag_own [READ_LAT];
  logic             tail_vld, tail_own;

  // Grants stay off until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  always_comb begin
    c_r_req  = |c_re;
    d_r_req  = |d_re;
    c_w_req  = |c_we;
    d_w_req  = |d_we;
    d_r_win  = run & d_r_req & (~c_r_req | (r_cnt == LIMIT));
    c_r_win  = run & c_r_req & ~d_r_win;
    d_w_win  = run & d_w_req & (~c_w_req | (w_cnt == LIMIT));
    c_w_win  = run & c_w_req & ~d_w_win;
    d_r_deny = run & d_r_req & ~d_r_win;
    d_w_deny = run & d_w_req & ~d_w_win;
  end

  // Winner's request is muxed straight onto the GLB; enables carry only the winner's mask.
  always_comb begin
    c_r_gnt    = c_r_win;
    d_r_gnt    = d_r_win;
    c_w_gnt    = c_w_win;
    d_w_gnt    = d_w_win;
    glb_re     = c_r_win ? c_re : (d_r_win ? d_re : 4'h0);
    glb_r_addr = d_r_win ? d_r_addr : c_r_addr;
    glb_we     = c_w_win ? c_we : (d_w_win ? d_we : 4'h0);
    glb_w_addr = d_w_win ? d_w_addr : c_w_addr;
    glb_w_data = d_w_win ? d_w_data : c_w_data;
  end

  // Loader starvation counters: count consecutive denials, clear on grant or on dropping the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      w_cnt <= '0;
    end else begin
      if (d_r_deny) r_cnt <= (r_cnt == LIMIT) ? r_cnt : r_cnt + CNT_W'(1);
      else          r_cnt <= '0;
      if (d_w_deny) w_cnt <= (w_cnt == LIMIT) ? w_cnt : w_cnt + CNT_W'(1);
      else          w_cnt <= '0;
    end
  end

  // Tag shift register mirrors the GLB read latency; owner 1 = loader.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_own[i] <= 1'b0;
      end
    end else begin
      tag_vld[0] <= c_r_win | d_r_win;
      tag_own[0] <= d_r_win;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  always_comb begin
    tail_vld  = tag_vld[READ_LAT-1];
    tail_own  = tag_own[READ_LAT-1];
    c_r_valid = tail_vld & ~tail_own;
    d_r_valid = tail_vld & tail_own;
    c_r_data  = c_r_valid ? glb_r_data : '0;
    d_r_data  = d_r_valid ? glb_r_data : '0;
  end

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Directed bench for glb_port_arbiter with a one-cycle-latency GLB read model.
module tb_glb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c_re, c_we, d_re, d_we, glb_re, glb_we;
  logic [31:0] c_r_addr, c_w_addr, c_w_data, d_r_addr, d_w_addr, d_w_data;
  logic [31:0] c_r_data, d_r_data, glb_r_addr, glb_w_addr, glb_w_data;
  logic [31:0] glb_r_data = 32'h0;
  logic        c_r_gnt, c_r_valid, c_w_gnt, d_r_gnt, d_r_valid, d_w_gnt;

  int checks = 0;
  int errors = 0;

  glb_port_arbiter #(.DATA_SIZE(32), .READ_LAT(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_re(c_re), .c_r_addr(c_r_addr), .c_r_gnt(c_r_gnt), .c_r_valid(c_r_valid), .c_r_data(c_r_data),
    .c_we(c_we), .c_w_addr(c_w_addr), .c_w_data(c_w_data), .c_w_gnt(c_w_gnt),
    .d_re(d_re), .d_r_addr(d_r_addr), .d_r_gnt(d_r_gnt), .d_r_valid(d_r_valid), .d_r_data(d_r_data),
    .d_we(d_we), .d_w_addr(d_w_addr), .d_w_data(d_w_data), .d_w_gnt(d_w_gnt),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A50000);
  endfunction

  // GLB read model: data appears one cycle after re/addr.
  always @(posedge clk) if (|glb_re) glb_r_data <= mem_val(glb_r_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [9:0] dpat;
  logic       dw;

  initial begin
    rst = 1'b0;
    c_re = 4'hF; c_r_addr = 32'h0; c_we = 4'h0; c_w_addr = 32'h0; c_w_data = 32'h0;
    d_re = 4'h0; d_r_addr = 32'h0; d_we = 4'hF; d_w_addr = 32'h0; d_w_data = 32'h0;
    dpat = 10'b10000_10000;

    // Reset held with requests pending
    repeat (2) cyc();
    #3;
    chk("rst_c_r_gnt", c_r_gnt, 0);
    chk("rst_d_w_gnt", d_w_gnt, 0);
    chk("rst_glb_re", glb_re, 0);
    chk("rst_glb_we", glb_we, 0);
    chk("rst_c_r_valid", c_r_valid, 0);
    chk("rst_d_r_valid", d_r_valid, 0);
    chk("rst_c_r_data", c_r_data, 0);

    cyc(); rst = 1'b1; #3;
    chk("rel_before_edge_gnt", c_r_gnt, 0);
    cyc(); #3;
    chk("rel_c_r_gnt", c_r_gnt, 1);
    chk("rel_d_w_gnt", d_w_gnt, 1);
    chk("rel_glb_re", glb_re, 4'hF);
    chk("rel_glb_we", glb_we, 4'hF);
    chk("rel_glb_r_addr", glb_r_addr, 32'h0);

    // Single loader read of 0x40
    cyc(); c_re = 4'h0; d_we = 4'h0; d_re = 4'hF; d_r_addr = 32'h40; #3;
    chk("ret_c_r_valid", c_r_valid, 1);
    chk("ret_c_r_data", c_r_data, 32'hA5A50000);
    chk("ret_d_r_valid_idle", d_r_valid, 0);
    chk("single_d_r_gnt", d_r_gnt, 1);
    chk("single_c_r_gnt", c_r_gnt, 0);
    chk("single_glb_r_addr", glb_r_addr, 32'h40);
    cyc(); d_re = 4'h0; #3;
    chk("single_d_r_valid", d_r_valid, 1);
    chk("single_d_r_data", d_r_data, 32'hDEADBEEF);
    chk("single_c_r_valid", c_r_valid, 0);
    chk("single_c_r_data", c_r_data, 0);

    // Continuous read contention: c,c,c,c,d repeating
    for (int i = 0; i < 10; i++) begin
      cyc(); c_re = 4'hF; c_r_addr = 32'h10; d_re = 4'hF; d_r_addr = 32'h20; #3;
      dw = dpat[i];
      chk($sformatf("cont_d_r_gnt_%0d", i), d_r_gnt, dw);
      chk($sformatf("cont_c_r_gnt_%0d", i), c_r_gnt, !dw);
      if (i > 0) begin
        chk($sformatf("cont_d_r_valid_%0d", i), d_r_valid, dpat[i-1]);
        chk($sformatf("cont_c_r_valid_%0d", i), c_r_valid, !dpat[i-1]);
        if (dpat[i-1]) chk($sformatf("cont_d_r_data_%0d", i), d_r_data, 32'hA5A50020);
        else           chk($sformatf("cont_c_r_data_%0d", i), c_r_data, 32'hA5A50010);
      end
    end
    cyc(); c_re = 4'h0; d_re = 4'h0; #3;
    chk("cont_last_d_r_valid", d_r_valid, 1);
    chk("cont_last_d_r_data", d_r_data, 32'hA5A50020);
    chk("cont_last_c_r_valid", c_r_valid, 0);

    // Independent ports: controller write with loader read
    cyc(); c_we = 4'hF; c_w_addr = 32'h100; c_w_data = 32'h11112222;
    d_re = 4'hF; d_r_addr = 32'h200; #3;
    chk("ind_c_w_gnt", c_w_gnt, 1);
    chk("ind_d_r_gnt", d_r_gnt, 1);
    chk("ind_glb_we", glb_we, 4'hF);
    chk("ind_glb_w_addr", glb_w_addr, 32'h100);
    chk("ind_glb_w_data", glb_w_data, 32'h11112222);
    chk("ind_glb_re", glb_re, 4'hF);
    chk("ind_glb_r_addr", glb_r_addr, 32'h200);

    // Write-port contention with a partial loader mask
    for (int i = 0; i < 5; i++) begin
      cyc(); d_re = 4'h0; d_we = 4'h3; d_w_addr = 32'h300; d_w_data = 32'h33334444; #3;
      chk($sformatf("wcont_d_w_gnt_%0d", i), d_w_gnt, (i == 4));
      chk($sformatf("wcont_c_w_gnt_%0d", i), c_w_gnt, (i != 4));
      chk($sformatf("wcont_glb_we_%0d", i), glb_we, (i == 4) ? 4'h3 : 4'hF);
      chk($sformatf("wcont_glb_w_data_%0d", i), glb_w_data, (i == 4) ? 32'h33334444 : 32'h11112222);
    end

    // Drop while starved restarts the count
    for (int i = 0; i < 9; i++) begin
      cyc(); c_we = 4'h0; d_we = 4'h0; c_re = 4'hF; c_r_addr = 32'h10;
      d_re = (i == 3) ? 4'h0 : 4'hF; d_r_addr = 32'h20; #3;
      chk($sformatf("drop_d_r_gnt_%0d", i), d_r_gnt, (i == 8));
      chk($sformatf("drop_c_r_gnt_%0d", i), c_r_gnt, (i != 8));
    end

    // Reset in the middle of a granted read
    cyc(); c_re = 4'h0; d_re = 4'hF; d_r_addr = 32'h40; #3;
    chk("mid_d_r_gnt", d_r_gnt, 1);
    #2; rst = 1'b0; #1;
    chk("mid_rst_d_r_gnt", d_r_gnt, 0);
    cyc(); d_re = 4'h0; #3;
    chk("mid_no_d_r_valid", d_r_valid, 0);
    chk("mid_no_d_r_data", d_r_data, 0);
    cyc(); rst = 1'b1;
    cyc(); cyc(); #3;
    chk("post_d_r_valid", d_r_valid, 0);
    chk("post_c_r_valid", c_r_valid, 0);
    cyc(); d_re = 4'hF; #3;
    chk("post_d_r_gnt", d_r_gnt, 1);
    cyc(); d_re = 4'h0; #3;
    chk("post_d_r_valid_ret", d_r_valid, 1);
    chk("post_d_r_data_ret", d_r_data, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
